// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes the datapath selects and write enables from the current state.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       waitrequest,
  input  logic       pc_zero,
  output logic       active,
  output logic [2:0] state,
  output logic       mem_read,
  output logic       mem_write,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t cur, nxt;

  logic is_rtype, is_jr, is_ialu, is_lw, is_sw, is_br, is_j, is_jal;

  always_comb begin
    is_rtype = (opcode == 6'b000000) && (funct != 6'b001000);
    is_jr    = (opcode == 6'b000000) && (funct == 6'b001000);
    is_ialu  = (opcode[5:3] == 3'b001) && (opcode[2:0] != 3'b000);
    is_lw    = (opcode == 6'b100011);
    is_sw    = (opcode == 6'b101011);
    is_br    = (opcode == 6'b000100) || (opcode == 6'b000101);
    is_j     = (opcode == 6'b000010);
    is_jal   = (opcode == 6'b000011);
  end

  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  // Outputs decode combinationally so the reset cycle can force them all low.
  always_comb begin
    nxt         = cur;
    active      = 1'b0;
    state       = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = '0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = '0;
    ALUOp       = '0;
    RegWrite    = 1'b0;
    RegDst      = '0;
    MemtoReg    = '0;
    if (!reset) begin
      active = (cur != HALT);
      state  = cur;
      case (cur)
        FETCH: begin
          if (pc_zero) begin
            nxt = HALT;
          end else begin
            mem_read = 1'b1;
            if (!waitrequest) begin
              IRWrite = 1'b1;
              PCWrite = 1'b1;
              ALUSrcB = 2'd1;
              nxt     = DECODE;
            end
          end
        end
        DECODE: begin
          ALUSrcB = 2'd3;
          nxt     = EXEC;
        end
        EXEC: begin
          nxt = FETCH;
          if (is_rtype) begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'd2;
            nxt     = WB;
          end else if (is_ialu) begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
            ALUOp   = 2'd3;
            nxt     = WB;
          end else if (is_lw || is_sw) begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
            nxt     = MEM;
          end else if (is_br) begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'd1;
            PCWriteCond = 1'b1;
            PCSource    = 2'd1;
          end else if (is_j || is_jal) begin
            PCWrite  = 1'b1;
            PCSource = 2'd2;
            if (is_jal) begin
              RegWrite = 1'b1;
              RegDst   = 2'd2;
              MemtoReg = 2'd2;
            end
          end else if (is_jr) begin
            PCWrite  = 1'b1;
            PCSource = 2'd3;
          end
        end
        MEM: begin
          IorD = 1'b1;
          if (is_lw) mem_read  = 1'b1;
          else       mem_write = 1'b1;
          if (!waitrequest) nxt = is_lw ? WB : FETCH;
        end
        WB: begin
          RegWrite = 1'b1;
          RegDst   = is_rtype ? 2'd1 : 2'd0;
          MemtoReg = is_lw ? 2'd1 : 2'd0;
          nxt      = FETCH;
        end
        HALT:    nxt = HALT;
        default: nxt = FETCH;
      endcase
    end
  end

endmodule
